// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared FIFO controller state encoding and buffer geometry
package fifo_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
   localparam int FIFO_DW = 32;
   localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
   parameter int N = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] j;
   // scan from farthest to nearest so the nearest requester at or after ptr wins
   always_comb begin
      idx = '0;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % N);
         idx = req[j] ? j : idx;
      end
      gnt = (|req) ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbitration and flush sequencing for a FIFO write port
module fifo_write_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int N = 4,
   parameter int DW = FIFO_DW,
   parameter int MAX_BURST = 8,
   parameter int FLUSH_CYCLES = 2,
   parameter int IW = $clog2(N)
) (
   input  logic            CLK,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*DW-1:0] data_in,
   input  logic [N-1:0]    last,
   output logic [N-1:0]    ack,
   input  logic            flush,
   input  logic            fifo_full,
   output logic            fifo_en,
   output logic            fifo_wr,
   output logic            fifo_rst,
   output logic [DW-1:0]   fifo_din,
   output logic [IW-1:0]   grant_id,
   output logic            busy
);
   localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   state_t state, state_n;
   logic [IW-1:0] rr_ptr, arb_idx;
   logic [N-1:0] arb_gnt;
   logic [BW-1:0] beat_cnt;
   logic [FW-1:0] fcnt;
   logic flush_pend, beat, burst_end;
   logic [DW-1:0] words [N];

   for (genvar g = 0; g < N; g++) begin : g_words
      assign words[g] = data_in[g*DW +: DW];
   end

   rr_arbiter #(.N(N), .IW(IW)) u_arb (
      .req(req),
      .ptr(rr_ptr),
      .gnt(arb_gnt),
      .idx(arb_idx)
   );

   // write-port outputs and next state; a flush always beats a new grant in IDLE
   always_comb begin
      beat = state == BURST && req[grant_id] && !fifo_full;
      burst_end = state == BURST && (!req[grant_id] || (beat && (last[grant_id] || beat_cnt == BW'(MAX_BURST - 1))));
      ack = beat ? (N'(1) << grant_id) : '0;
      fifo_wr = beat;
      fifo_din = beat ? words[grant_id] : '0;
      fifo_rst = state == FLUSH;
      busy = state != IDLE;
      state_n = state;
      case (state)
         IDLE:    state_n = (flush || flush_pend) ? FLUSH : (|arb_gnt) ? BURST : IDLE;
         BURST:   state_n = burst_end ? IDLE : BURST;
         FLUSH:   state_n = fcnt == FW'(FLUSH_CYCLES - 1) ? IDLE : FLUSH;
         default: state_n = IDLE;
      endcase
   end

   // state, grant bookkeeping, beat and flush counters, deferred flush request
   always_ff @(posedge CLK) begin
      if (!rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
         fcnt <= '0;
         flush_pend <= 1'b0;
         fifo_en <= 1'b0;
      end else begin
         state <= state_n;
         fifo_en <= 1'b1;
         grant_id <= (state == IDLE && state_n == BURST) ? arb_idx : grant_id;
         rr_ptr <= burst_end ? ((grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1) : rr_ptr;
         beat_cnt <= (state == IDLE) ? '0 : beat ? beat_cnt + 1'b1 : beat_cnt;
         fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
         flush_pend <= (state == FLUSH && state_n == IDLE) ? 1'b0 : flush_pend | (flush && state == BURST);
      end
   end
endmodule
